// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART hex command parser.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_PEND
    } state_t;

    localparam logic [7:0] START_CHAR_DEF   = 8'h4C;
    localparam logic [7:0] ASCII_CR         = 8'h0D;
    localparam logic [7:0] ASCII_LF         = 8'h0A;
    localparam int         NIBBLES_PER_WORD = 8;

endpackage

// File: rtl/hex_ascii_decode.sv
// Combinational ASCII hex digit decoder: byte -> {is_hex, nibble}.
module hex_ascii_decode (
    input  logic [7:0] byte_in,
    output logic       is_hex,
    output logic [3:0] nibble
);

    always_comb begin
        is_hex = 1'b0;
        nibble = 4'd0;
        if (byte_in >= 8'h30 && byte_in <= 8'h39) begin
            is_hex = 1'b1;
            nibble = byte_in[3:0];
        end else if ((byte_in >= 8'h41 && byte_in <= 8'h46) ||
                     (byte_in >= 8'h61 && byte_in <= 8'h66)) begin
            // 'A'/'a' carry 1 in the low nibble, so adding 9 lands on 10
            is_hex = 1'b1;
            nibble = byte_in[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses "L" + 24 ASCII hex chars into {command, address, data} for wishbone_master.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] START_CHAR     = START_CHAR_DEF,
    parameter int         TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_available,
    input  logic [7:0]  byte_in,
    input  logic        master_ready,
    output logic [31:0] command,
    output logic [31:0] address,
    output logic [31:0] data,
    output logic        ready,
    output logic        frame_error,
    output logic        busy
);

    localparam int TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [2:0]      LAST_NIB = 3'(NIBBLES_PER_WORD - 1);

    state_t          state, state_nxt;
    logic            is_hex;
    logic [3:0]      nibble;
    logic [31:0]     sr;
    logic [31:0]     word;
    logic [2:0]      nib_cnt;
    logic [TO_W-1:0] to_cnt;
    logic            in_word, in_word_nxt, timeout_hit, accept, word_done, start;
    logic            ready_nxt, error_nxt;

    hex_ascii_decode u_dec (
        .byte_in (byte_in),
        .is_hex  (is_hex),
        .nibble  (nibble)
    );

    assign in_word     = (state == ST_CMD) || (state == ST_ADDR) || (state == ST_DATA);
    assign in_word_nxt = (state_nxt == ST_CMD) || (state_nxt == ST_ADDR) || (state_nxt == ST_DATA);
    // to_cnt holds the cycles elapsed since the last accepted byte, so the
    // abort is registered exactly TIMEOUT_CYCLES cycles after that byte
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && in_word && (to_cnt == TO_LAST);
    assign accept      = in_word && byte_available && is_hex && !timeout_hit;
    assign word_done   = accept && (nib_cnt == LAST_NIB);
    assign word        = {sr[27:0], nibble};
    assign start       = (state == ST_IDLE) && byte_available && (byte_in == START_CHAR);
    assign busy        = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        ready_nxt = 1'b0;
        error_nxt = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_CMD;
            end
            ST_CMD, ST_ADDR, ST_DATA: begin
                if (timeout_hit || (byte_available && !is_hex)) begin
                    error_nxt = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (word_done) begin
                    if (state == ST_CMD) begin
                        state_nxt = ST_ADDR;
                    end else if (state == ST_ADDR) begin
                        state_nxt = ST_DATA;
                    end else if (master_ready) begin
                        ready_nxt = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                // a stray byte is reported but never costs the pending command
                if (byte_available) begin
                    error_nxt = 1'b1;
                end else if (master_ready) begin
                    ready_nxt = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            ready       <= 1'b0;
            frame_error <= 1'b0;
            nib_cnt     <= 3'd0;
            to_cnt      <= '0;
        end else begin
            state       <= state_nxt;
            ready       <= ready_nxt;
            frame_error <= error_nxt;
            if (start) begin
                nib_cnt <= 3'd0;
            end else if (accept) begin
                nib_cnt <= nib_cnt + 3'd1;
            end
            if (!in_word_nxt) begin
                to_cnt <= '0;
            end else if (start || accept) begin
                to_cnt <= TO_W'(1);
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            sr <= '0;
        end else if (accept) begin
            sr <= word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            command <= '0;
            address <= '0;
            data    <= '0;
        end else if (word_done) begin
            unique case (state)
                ST_CMD:  command <= word;
                ST_ADDR: address <= word;
                ST_DATA: data    <= word;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed and randomized checks of uart_cmd_parser against a string-level frame model.
module tb_uart_cmd_parser;

    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        byte_available = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        master_ready = 1'b1;
    logic [31:0] command, address, data;
    logic        ready, frame_error, busy;

    uart_cmd_parser #(.START_CHAR(8'h4C), .TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .byte_available (byte_available),
        .byte_in        (byte_in),
        .master_ready   (master_ready),
        .command        (command),
        .address        (address),
        .data           (data),
        .ready          (ready),
        .frame_error    (frame_error),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          rdy_pulses = 0;
    int          err_pulses = 0;
    int          both_cnt = 0;
    logic [95:0] cap_q[$];
    logic [7:0]  stim_q[$];
    logic [95:0] exp_q[$];
    int          exp_err;

    always @(negedge clk) begin
        if (ready === 1'b1) begin
            rdy_pulses++;
            cap_q.push_back({command, address, data});
        end
        if (frame_error === 1'b1) err_pulses++;
        if (ready === 1'b1 && frame_error === 1'b1) both_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in = b;
        byte_available = 1'b1;
        tick();
        byte_available = 1'b0;
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(8'(s[i]));
            repeat (gap) tick();
        end
    endtask

    function automatic bit is_hex_c(input logic [7:0] c);
        return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
    endfunction

    function automatic logic [3:0] hex_val(input logic [7:0] c);
        if (c <= "9") return 4'(c - 8'h30);
        if (c >= "a") return 4'(c - 8'h61 + 8'd10);
        return 4'(c - 8'h41 + 8'd10);
    endfunction

    // A frame is 'L' followed by 24 hex chars; the first non-hex char aborts it and is consumed.
    task automatic run_model();
        int          i;
        int          n;
        int          got;
        logic [95:0] acc;
        exp_q.delete();
        exp_err = 0;
        i = 0;
        n = stim_q.size();
        while (i < n) begin
            if (stim_q[i] != 8'h4C) begin
                i++;
            end else begin
                acc = '0;
                got = 0;
                i++;
                while (got < 24 && i < n && is_hex_c(stim_q[i])) begin
                    acc = {acc[91:0], hex_val(stim_q[i])};
                    got++;
                    i++;
                end
                if (got == 24) begin
                    exp_q.push_back(acc);
                end else if (i < n) begin
                    exp_err++;
                    i++;
                end
            end
        end
    endtask

    function automatic logic [7:0] rand_hex();
        int v;
        v = int'($urandom_range(0, 15));
        if (v < 10) return 8'(8'h30 + v);
        return 8'((($urandom_range(0, 1) == 1) ? 8'h61 : 8'h41) + v - 10);
    endfunction

    initial begin
        int          r0;
        int          e0;
        int          c0;
        bit          early;
        logic [7:0]  junk[5];
        logic [7:0]  badc[5];
        logic [95:0] got;

        junk = '{8'h0D, 8'h0A, 8'h20, 8'h78, 8'h35};
        badc = '{8'h47, 8'h4C, 8'h0D, 8'h7A, 8'h20};

        // reset state
        repeat (3) tick();
        chk("rst_cmd", 96'(command), 96'h0);
        chk("rst_addr", 96'(address), 96'h0);
        chk("rst_data", 96'(data), 96'h0);
        chk("rst_flags", 96'({ready, frame_error, busy}), 96'h0);
        rst = 1'b0;
        tick();

        // basic frame with latency
        r0 = rdy_pulses; e0 = err_pulses;
        send_str("L0000000100000100DEADBEEF", 0);
        chk("t1_ready_latency", 96'(ready), 96'h1);
        repeat (3) tick();
        chk("t1_ready_count", 96'(rdy_pulses - r0), 96'd1);
        chk("t1_err_count", 96'(err_pulses - e0), 96'd0);
        chk("t1_words", {command, address, data}, {32'h1, 32'h100, 32'hDEADBEEF});

        // bad char aborts, next frame still parses
        r0 = rdy_pulses; e0 = err_pulses;
        send_str("L0000000G", 0);
        chk("t3_err_pulse", 96'(frame_error), 96'h1);
        chk("t3_busy_drop", 96'(busy), 96'h0);
        send_str("L123456789ABCDEF00F1E2D3C", 1);
        repeat (3) tick();
        chk("t3_err_count", 96'(err_pulses - e0), 96'd1);
        chk("t3_ready_count", 96'(rdy_pulses - r0), 96'd1);
        chk("t3_words", {command, address, data}, {32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C});

        // lowercase with CR/LF around the frame
        r0 = rdy_pulses; e0 = err_pulses; c0 = cap_q.size();
        send_byte(8'h0D); send_byte(8'h0A);
        send_str("L0000000100000100deadbeef", 1);
        send_byte(8'h0D); send_byte(8'h0A);
        repeat (3) tick();
        chk("t2_ready_count", 96'(rdy_pulses - r0), 96'd1);
        chk("t2_err_count", 96'(err_pulses - e0), 96'd0);
        got = (cap_q.size() > c0) ? cap_q[c0] : 'x;
        chk("t2_words", got, {32'h1, 32'h100, 32'hDEADBEEF});

        // pending with a stray byte
        r0 = rdy_pulses; e0 = err_pulses;
        master_ready = 1'b0;
        send_str("LCAFEF00D1111222233334444", 0);
        chk("t4_pend_busy", 96'({ready, busy}), 96'h1);
        repeat (20) tick();
        send_byte(8'h35);
        chk("t4_stray_err", 96'({frame_error, busy}), 96'h3);
        repeat (28) tick();
        chk("t4_hold_words", {command, address, data}, {32'hCAFEF00D, 32'h11112222, 32'h33334444});
        chk("t4_no_early_ready", 96'(rdy_pulses - r0), 96'd0);
        master_ready = 1'b1;
        tick();
        chk("t4_ready_latency", 96'(ready), 96'h1);
        chk("t4_ready_words", {command, address, data}, {32'hCAFEF00D, 32'h11112222, 32'h33334444});
        repeat (3) tick();
        chk("t4_err_count", 96'(err_pulses - e0), 96'd1);
        chk("t4_ready_count", 96'(rdy_pulses - r0), 96'd1);

        // timeout after "L0123"
        e0 = err_pulses;
        send_str("L0123", 0);
        chk("t5_busy", 96'(busy), 96'h1);
        early = 1'b0;
        repeat (TO - 1) begin
            if (frame_error !== 1'b0) early = 1'b1;
            tick();
        end
        chk("t5_no_early_err", 96'(early), 96'h0);
        chk("t5_err_at_timeout", 96'(frame_error), 96'h1);
        chk("t5_idle", 96'(busy), 96'h0);
        tick();
        chk("t5_err_count", 96'(err_pulses - e0), 96'd1);

        // reset mid-frame
        r0 = rdy_pulses; e0 = err_pulses;
        send_str("LAAAAAAAABBBBBBBB", 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_words_zero", {command, address, data}, 96'h0);
        chk("t6_flags_zero", 96'({ready, frame_error, busy}), 96'h0);
        send_str("CCCCCCCC", 1);
        repeat (3) tick();
        chk("t6_no_ready", 96'(rdy_pulses - r0), 96'd0);
        chk("t6_no_err", 96'(err_pulses - e0), 96'd0);

        // randomized frame stream
        stim_q.delete();
        for (int f = 0; f < 40; f++) begin
            int nj;
            int badpos;
            nj = int'($urandom_range(0, 3));
            for (int j = 0; j < nj; j++) stim_q.push_back(junk[$urandom_range(0, 4)]);
            badpos = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 23)) : -1;
            stim_q.push_back(8'h4C);
            for (int k = 0; k < 24; k++) begin
                if (k == badpos) stim_q.push_back(badc[$urandom_range(0, 4)]);
                else stim_q.push_back(rand_hex());
            end
        end
        run_model();
        r0 = rdy_pulses; e0 = err_pulses; c0 = cap_q.size();
        foreach (stim_q[i]) begin
            send_byte(stim_q[i]);
            repeat ($urandom_range(0, 3)) tick();
        end
        repeat (5) tick();
        chk("rnd_ready_count", 96'(rdy_pulses - r0), 96'(exp_q.size()));
        chk("rnd_err_count", 96'(err_pulses - e0), 96'(exp_err));
        foreach (exp_q[i]) begin
            got = (c0 + i < cap_q.size()) ? cap_q[c0 + i] : 'x;
            chk($sformatf("rnd_frame%0d", i), got, exp_q[i]);
        end
        chk("no_ready_error_overlap", 96'(both_cnt), 96'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
